// File: rtl/alu_pkg.sv
// alu_pkg: ALU op-code encodings and RV32I major opcodes shared by decode, issue and ALU.
package alu_pkg;
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
endpackage

// File: rtl/alu_issue_decode.sv
// alu_issue_decode: combinational mapping of instruction fields onto ALU operands, op and illegal flag.
module alu_issue_decode
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic            funct7b5,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] a,
    output logic [XLEN-1:0] b,
    output logic [3:0]      op,
    output logic            illegal
);
    logic is_op, is_imm, is_lui, is_auipc, bad_arith, legal, shift;
    logic [3:0] arith_op;
    logic [XLEN-1:0] b_raw;
    always_comb begin
        is_op     = opcode == OPC_OP;
        is_imm    = opcode == OPC_OP_IMM;
        is_lui    = opcode == OPC_LUI;
        is_auipc  = opcode == OPC_AUIPC;
        arith_op  = funct3 == 3'b000 ? (is_op && funct7b5 ? ALU_SUB : ALU_ADD)
                  : funct3 == 3'b101 ? (funct7b5 ? ALU_SRA : ALU_SRL)
                  : {1'b0, funct3};
        // For OP-IMM, bit 30 is ordinary immediate data except on the shift encodings.
        bad_arith = is_op ? funct7b5 && funct3 != 3'b000 && funct3 != 3'b101
                          : funct7b5 && funct3 == 3'b001;
        legal     = ((is_op || is_imm) && !bad_arith) || is_lui || is_auipc;
        illegal   = !legal;
        op        = legal && (is_op || is_imm) ? arith_op : ALU_ADD;
        shift     = op == ALU_SLL || op == ALU_SRL || op == ALU_SRA;
        b_raw     = !legal ? '0 : is_op ? rs2_val : imm;
        b         = shift ? {{(XLEN-5){1'b0}}, b_raw[4:0]} : b_raw;
        a         = !legal || is_lui ? '0 : is_auipc ? pc : rs1_val;
    end
endmodule

// File: rtl/alu_issue.sv
// alu_issue: operand-issue stage with a 2-entry skid buffer, registered in_ready and issue counter.
module alu_issue
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      in_opcode,
    input  logic [2:0]      in_funct3,
    input  logic            in_funct7b5,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [XLEN-1:0] in_rs2_val,
    input  logic [XLEN-1:0] in_imm,
    input  logic [XLEN-1:0] in_pc,
    input  logic [RD_W-1:0] in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_op,
    output logic [RD_W-1:0] out_rd,
    output logic            out_illegal,
    output logic [31:0]     issued_cnt
);
    localparam int W = 2 * XLEN + 4 + RD_W + 1;
    logic [XLEN-1:0] dec_a, dec_b;
    logic [3:0] dec_op;
    logic dec_ill, main_valid, skid_valid, accept, consume;
    logic [W-1:0] dec, main_q, skid_q;

    alu_issue_decode #(.XLEN(XLEN)) u_decode (
        .opcode(in_opcode), .funct3(in_funct3), .funct7b5(in_funct7b5),
        .rs1_val(in_rs1_val), .rs2_val(in_rs2_val), .imm(in_imm), .pc(in_pc),
        .a(dec_a), .b(dec_b), .op(dec_op), .illegal(dec_ill)
    );

    assign dec       = {dec_a, dec_b, dec_op, in_rd, dec_ill};
    assign {alu_a, alu_b, alu_op, out_rd, out_illegal} = main_q;
    assign out_valid = main_valid;
    assign in_ready  = !skid_valid;
    assign accept    = in_valid && !skid_valid;
    assign consume   = main_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
            issued_cnt <= '0;
        end else begin
            issued_cnt <= issued_cnt + 32'(consume);
            if (flush) begin
                main_valid <= 1'b0;
                skid_valid <= 1'b0;
            end else if (consume || !main_valid) begin
                // Skid is only ever occupied while main is, so it always drains first.
                main_valid <= skid_valid || accept;
                skid_valid <= 1'b0;
                if (skid_valid)
                    main_q <= skid_q;
                else if (accept)
                    main_q <= dec;
            end else if (accept) begin
                skid_q     <= dec;
                skid_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: table-driven vectors with a scoreboard queue plus handshake, stall and flush sequences.
module tb_alu_issue;
    logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
    logic in_ready, out_valid, out_illegal, in_funct7b5 = 0;
    logic [6:0] in_opcode = 0;
    logic [2:0] in_funct3 = 0;
    logic [31:0] in_rs1_val = 0, in_rs2_val = 0, in_imm = 0, in_pc = 0;
    logic [4:0] in_rd = 0, out_rd;
    logic [31:0] alu_a, alu_b, issued_cnt;
    logic [3:0] alu_op;

    alu_issue dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm), .in_pc(in_pc),
        .in_rd(in_rd), .out_valid(out_valid), .out_ready(out_ready), .alu_a(alu_a),
        .alu_b(alu_b), .alu_op(alu_op), .out_rd(out_rd), .out_illegal(out_illegal),
        .issued_cnt(issued_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] opc; logic [2:0] f3; logic f7;
        logic [31:0] rs1, rs2, imm, pc; logic [4:0] rd;
        logic [31:0] a, b; logic [3:0] op; logic ill;
    } vec_t;
    typedef struct { logic [31:0] a, b; logic [3:0] op; logic [4:0] rd; logic ill; } exp_t;

    vec_t vecs[13];
    exp_t q[$];
    exp_t e;
    int checks = 0, errors = 0;
    logic [31:0] sa, sb;
    logic [3:0] sop;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output got a=%h b=%h expected nothing", alu_a, alu_b);
            end else begin
                e = q.pop_front();
                chk("alu_a", alu_a, e.a);
                chk("alu_b", alu_b, e.b);
                chk("alu_op", {28'b0, alu_op}, {28'b0, e.op});
                chk("out_rd", {27'b0, out_rd}, {27'b0, e.rd});
                chk("out_illegal", {31'b0, out_illegal}, {31'b0, e.ill});
            end
        end
    end

    task automatic send(input vec_t v, input logic fl);
        int t = 0;
        in_opcode = v.opc; in_funct3 = v.f3; in_funct7b5 = v.f7;
        in_rs1_val = v.rs1; in_rs2_val = v.rs2; in_imm = v.imm; in_pc = v.pc; in_rd = v.rd;
        in_valid = 1; flush = fl;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout got in_ready=0 expected 1");
        end else if (!fl) q.push_back('{v.a, v.b, v.op, v.rd, v.ill});
        @(posedge clk);
        #1 in_valid = 0; flush = 0;
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && q.size() > 0; t++) @(posedge clk);
        chk("drain_pending", q.size(), 0);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    initial begin
        //        opc         f3    f7  rs1           rs2           imm           pc            rd   a             b             op     ill
        vecs[0]  = '{7'b0110011, 3'b000, 0, 32'd5,        32'd7,        32'd0,        32'd0,        5'd3, 32'd5,        32'd7,        4'h0, 0};
        vecs[1]  = '{7'b0110011, 3'b000, 1, 32'd10,       32'd3,        32'd0,        32'd0,        5'd4, 32'd10,       32'd3,        4'h8, 0};
        vecs[2]  = '{7'b0010011, 3'b101, 1, 32'h80000000, 32'd9,        32'h404,      32'd0,        5'd5, 32'h80000000, 32'd4,        4'hD, 0};
        vecs[3]  = '{7'b0010111, 3'b000, 0, 32'hdead,     32'd0,        32'h2000,     32'h1000,     5'd6, 32'h1000,     32'h2000,     4'h0, 0};
        vecs[4]  = '{7'b0110111, 3'b010, 0, 32'hffff,     32'd1,        32'h12345000, 32'h40,       5'd7, 32'd0,        32'h12345000, 4'h0, 0};
        vecs[5]  = '{7'b0000011, 3'b010, 0, 32'h1234,     32'h55,       32'h8,        32'h40,       5'd8, 32'd0,        32'd0,        4'h0, 1};
        vecs[6]  = '{7'b0110011, 3'b111, 1, 32'h1234,     32'h55,       32'd0,        32'd0,        5'd9, 32'd0,        32'd0,        4'h0, 1};
        vecs[7]  = '{7'b0110011, 3'b001, 0, 32'hf,        32'h123,      32'd0,        32'd0,        5'd10, 32'hf,       32'h3,        4'h1, 0};
        vecs[8]  = '{7'b0110011, 3'b011, 0, 32'd1,        32'd2,        32'd0,        32'd0,        5'd11, 32'd1,       32'd2,        4'h3, 0};
        vecs[9]  = '{7'b0010011, 3'b000, 1, 32'd7,        32'd0,        32'hfffffc00, 32'd0,        5'd12, 32'd7,       32'hfffffc00, 4'h0, 0};
        vecs[10] = '{7'b0010011, 3'b001, 1, 32'd7,        32'd0,        32'h401,      32'd0,        5'd13, 32'd0,       32'd0,        4'h0, 1};
        vecs[11] = '{7'b0010011, 3'b110, 0, 32'h100,      32'd0,        32'hff,       32'd0,        5'd14, 32'h100,     32'hff,       4'h6, 0};
        vecs[12] = '{7'b0110011, 3'b101, 0, 32'h80,       32'h21,       32'd0,        32'd0,        5'd15, 32'h80,      32'd1,        4'h5, 0};

        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_in_ready", {31'b0, in_ready}, 1);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_op", {28'b0, alu_op}, 0);
        chk("rst_out_rd", {27'b0, out_rd}, 0);
        chk("rst_illegal", {31'b0, out_illegal}, 0);
        chk("rst_issued_cnt", issued_cnt, 0);
        @(posedge clk);
        #1 rst_n = 1;

        out_ready = 1;
        send(vecs[0], 0);
        chk("latency_out_valid", {31'b0, out_valid}, 1);
        @(posedge clk);
        #1 chk("issued_after_first", issued_cnt, 1);

        for (int i = 0; i < 13; i++) send(vecs[i], 0);
        drain();
        chk("issued_after_table", issued_cnt, 14);

        out_ready = 0;
        send(vecs[0], 0);
        send(vecs[1], 0);
        chk("full_in_ready", {31'b0, in_ready}, 0);
        sa = alu_a; sb = alu_b; sop = alu_op;
        repeat (3) @(posedge clk);
        #1;
        chk("stall_alu_a", alu_a, 32'd5);
        chk("stall_stable_a", alu_a, sa);
        chk("stall_stable_b", alu_b, sb);
        chk("stall_stable_op", {28'b0, alu_op}, {28'b0, sop});
        fork
            send(vecs[2], 0);
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1;
            end
        join
        drain();
        chk("issued_after_stall", issued_cnt, 17);

        out_ready = 0;
        send(vecs[3], 0);
        send(vecs[4], 0);
        in_opcode = vecs[5].opc; in_rd = vecs[5].rd;
        in_valid = 1; flush = 1;
        @(posedge clk);
        #1 in_valid = 0; flush = 0;
        q.delete();
        chk("flush_out_valid", {31'b0, out_valid}, 0);
        chk("flush_in_ready", {31'b0, in_ready}, 1);
        chk("flush_issued_cnt", issued_cnt, 17);
        out_ready = 1;
        send(vecs[8], 0);
        drain();
        chk("issued_after_flush", issued_cnt, 18);

        out_ready = 0;
        send(vecs[7], 1);
        chk("flush_beats_accept", {31'b0, out_valid}, 0);

        out_ready = 1;
        send(vecs[0], 0);
        flush = 1;
        @(posedge clk);
        #1 flush = 0;
        chk("flush_consume_count", issued_cnt, 19);
        chk("flush_consume_valid", {31'b0, out_valid}, 0);

        out_ready = 0;
        send(vecs[1], 0);
        send(vecs[2], 0);
        #2 rst_n = 0;
        #1;
        q.delete();
        chk("async_rst_valid", {31'b0, out_valid}, 0);
        chk("async_rst_ready", {31'b0, in_ready}, 1);
        chk("async_rst_cnt", issued_cnt, 0);
        @(posedge clk);
        #1 rst_n = 1;
        out_ready = 1;
        send(vecs[11], 0);
        drain();
        chk("issued_after_reset", issued_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_issue.md
# alu_issue

Operand-issue stage sitting directly upstream of the combinational ALU in the RV32I execute path. Accepts one decoded instruction per cycle from the decode stage and selects the ALU operands. Maps opcode/funct fields onto the ALU's 4-bit op encoding and presents registered `alu_a`/`alu_b`/`alu_op` under a valid/ready handshake. A 2-entry skid buffer gives full throughput with a registered `in_ready`.

## Interface
- `XLEN`, 32: operand width.
- `RD_W`, 5: destination register index width.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `flush`  in  1  synchronous pipeline flush; discards all buffered entries.
- `in_valid`  in  1  decode offers an instruction.
- `in_ready`  out  1  stage can accept.
- `in_opcode`  in  7  instruction bits [6:0].
- `in_funct3`  in  3  instruction bits [14:12].
- `in_funct7b5`  in  1  instruction bit 30.
- `in_rs1_val`, `in_rs2_val`, `in_imm`, `in_pc`  in  XLEN each  register values, sign-extended immediate, instruction PC.
- `in_rd`  in  RD_W  destination index.
- `out_valid`  out  1  ALU inputs valid.
- `out_ready`  in  1  downstream consumes this cycle.
- `alu_a`, `alu_b`  out  XLEN  ALU operands.
- `alu_op`  out  4  ALU op code.
- `out_rd`  out  RD_W  destination index, carried alongside.
- `out_illegal`  out  1  entry decoded as illegal.
- `issued_cnt`  out  32  count of completed output transfers.

## Operation
- ALU op codes: ADD 0000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, OR 0110, AND 0111, SUB 1000, SRA 1101.
- OP (0110011): a=rs1, b=rs2.
  - funct3 000: ADD, or SUB when funct7b5=1.
  - funct3 101: SRL, or SRA when funct7b5=1.
  - Other funct3: the matching code above.
  - funct7b5=1 with any other funct3: illegal.
- OP-IMM (0010011): a=rs1, b=imm, same mapping, except:
  - funct3 000 ignores funct7b5 (always ADD).
  - funct7b5=1 with funct3 001 (SLLI): illegal.
- LUI (0110111): a=0, b=imm, ADD.
- AUIPC (0010111): a=pc, b=imm, ADD.
- Any other opcode: illegal.
- Illegal entries still flow through with a=0, b=0, op=ADD, `out_illegal`=1.
- Shift ops (SLL/SRL/SRA): b is forced to {27'b0, b[4:0]}. The ALU shifts by the full b, so this masking is mandatory here.
- Buffer: main register (drives the outputs) plus one skid register.
- `in_ready` = !skid_valid, taken from a flop.
- Accept when in_valid && in_ready. An entry goes to main if main is empty or is being consumed this cycle; otherwise it goes to skid.
- Consume when out_valid && out_ready. Skid then moves to main.
- `issued_cnt` increments on every consume and wraps 0xFFFFFFFF→0.

## Timing
- Reset (async assert, sync-style deassert): out_valid=0, skid empty, in_ready=1, alu_a=alu_b=0, alu_op=0000, out_rd=0, out_illegal=0, issued_cnt=0.
- Latency: accept in cycle N → out_valid in N+1 when empty. Throughput is 1 per cycle when out_ready is held high.
- While out_valid && !out_ready, all out_* fields stay stable.
- Full (main and skid occupied): in_ready=0 from the next cycle; no entry is lost.
- Simultaneous accept and consume with skid empty: the new entry replaces main; occupancy is unchanged.
- Simultaneous accept and consume with skid full: cannot occur, because in_ready=0.
- Flush:
  - Clears main and skid next edge; out_valid=0 and in_ready=1 in the following cycle.
  - Overrides a same-cycle accept.
  - A same-cycle consume still counts in `issued_cnt`.
- Reset mid-operation drops all entries immediately.

## Structure
- `alu_pkg`: ALU op-code localparams and RV32I opcode constants (OP, OP_IMM, LUI, AUIPC). Shared with the ALU and decode stages.
- Sub-module `alu_issue_decode`: purely combinational field→{a, b, op, illegal} mapping. The top level holds the skid buffer, handshake logic and counter.

## Test plan
- `add x3`, rs1=5, rs2=7, continuous out_ready → out_valid in the next cycle, a=5, b=7, op=0000, illegal=0; issued_cnt=1.
- SRAI, rs1=0x80000000, imm=0x00000404 (funct7b5=1) → op=1101, b=0x00000004.
- AUIPC, pc=0x1000, imm=0x00002000 → a=0x1000, b=0x2000, op=0000.
- Illegal cases: opcode 0000011 → illegal=1, a=b=0, op=0000; R-type funct3=111 with funct7b5=1 → illegal=1.
- Backpressure: 3 back-to-back inputs with out_ready=0 → in_ready drops after 2 accepts. Release out_ready → outputs appear in order, values stable while stalled, issued_cnt=3.
- Flush with both entries full, in_valid=1 the same cycle → next cycle out_valid=0, in_ready=1; the flushed entries never appear.
